mux_sel_sequencer: RTL and testbench

Upstream feeder for the team's 8:1 mux stage (mux8to1). It accepts an 8-bit parallel word over a valid/ready handshake and latches it. It then steps a 3-bit select through 0..7, holding each index for HOLD cycles, and presents the latched word, current select and selected bit to the mux. The result is a parallel-to-serial converter with downstream backpressure; the in-block bit selection must match mux8to1 exactly.

---
 rtl/mux_sel_sequencer.sv | 79 +++++++
 tb/tb_mux_sel_sequencer.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/mux_sel_sequencer.sv
// Parallel-to-serial feeder for mux8to1: latches a word, steps sel through
// 0..WIDTH-1 (each index held HOLD beats) and honours downstream backpressure.
module mux_sel_sequencer #(
  parameter int WIDTH = 8,
  parameter int SEL_W = 3,
  parameter int HOLD  = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] a,
  output logic [SEL_W-1:0] sel,
  output logic             ser_out,
  output logic             ser_valid,
  input  logic             ser_ready,
  output logic             ser_last,
  output logic             done
);

  // state | meaning
  // IDLE  | no frame in flight, waiting for a word
  // RUN   | serializing the latched word, sel/hold_cnt advance on ser_ready
  typedef enum logic {IDLE, RUN} state_t;

  localparam int HW = (HOLD > 1) ? $clog2(HOLD) : 1;
  localparam logic [HW-1:0]    HOLD_M1  = HW'(HOLD - 1);
  localparam logic [SEL_W-1:0] LAST_SEL = SEL_W'(WIDTH - 1);

  state_t          state;
  logic [HW-1:0]   hold_cnt;

  assign ser_valid = (state == RUN);
  assign ser_last  = (state == RUN) && (sel == LAST_SEL) && (hold_cnt == HOLD_M1);
  assign in_ready  = (state == IDLE) || (ser_last && ser_ready);
  assign ser_out   = a[sel];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      a        <= '0;
      sel      <= '0;
      hold_cnt <= '0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          sel      <= '0;
          hold_cnt <= '0;
          if (in_valid) begin
            a     <= in_data;
            state <= RUN;
          end
        end
        RUN: begin
          if (ser_ready) begin
            if (ser_last) begin
              sel      <= '0;
              hold_cnt <= '0;
              done     <= 1'b1;
              // a following word chains straight into the next frame
              if (in_valid) a <= in_data;
              else          state <= IDLE;
            end else if (hold_cnt != HOLD_M1) begin
              hold_cnt <= hold_cnt + HW'(1);
            end else begin
              hold_cnt <= '0;
              sel      <= sel + SEL_W'(1);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mux_sel_sequencer.sv
// Scoreboard bench: two instances (HOLD=1 and HOLD=3); expected beats are
// queued when a word is driven and popped as the DUT presents bits.
module tb_mux_sel_sequencer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] in_data = '0;
  logic       ser_ready = 1'b1;

  logic       iv1 = 1'b0, ir1, so1, sv1, sl1, d1;
  logic [7:0] a1;
  logic [2:0] sel1;
  logic       iv3 = 1'b0, ir3, so3, sv3, sl3, d3;
  logic [7:0] a3;
  logic [2:0] sel3;

  int cmp_cnt = 0;
  int err_cnt = 0;
  int cyc = 0;

  logic [4:0] q1[$];
  logic [4:0] q3[$];
  logic [4:0] e1, e3;
  logic       pl1 = 1'b0, pl3 = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mux_sel_sequencer #(.WIDTH(8), .SEL_W(3), .HOLD(1)) u1 (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(iv1), .in_ready(ir1),
    .a(a1), .sel(sel1), .ser_out(so1), .ser_valid(sv1), .ser_ready(ser_ready),
    .ser_last(sl1), .done(d1));

  mux_sel_sequencer #(.WIDTH(8), .SEL_W(3), .HOLD(3)) u3 (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(iv3), .in_ready(ir3),
    .a(a3), .sel(sel3), .ser_out(so3), .ser_valid(sv3), .ser_ready(ser_ready),
    .ser_last(sl3), .done(d3));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    cmp_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // beat entry: {last, bit, sel}
  task automatic push_frame(input logic [7:0] w, input int hold, input bit to3);
    for (int s = 0; s < 8; s++)
      for (int h = 0; h < hold; h++) begin
        if (to3) q3.push_back({(s == 7 && h == hold - 1), w[s], 3'(s)});
        else     q1.push_back({(s == 7 && h == hold - 1), w[s], 3'(s)});
      end
  endtask

  always @(negedge clk) begin
    if (!rst_n) pl1 = 1'b0;
    else begin
      check("done1", d1, pl1);
      pl1 = 1'b0;
      if (sv1) begin
        if (q1.size() == 0) check("q1_underrun", 1, 0);
        else begin
          e1 = q1[0];
          check("sel1", sel1, e1[2:0]);
          check("bit1", so1, e1[3]);
          check("last1", sl1, e1[4]);
          if (ser_ready) begin
            void'(q1.pop_front());
            pl1 = e1[4];
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    if (!rst_n) pl3 = 1'b0;
    else begin
      check("done3", d3, pl3);
      pl3 = 1'b0;
      if (sv3) begin
        if (q3.size() == 0) check("q3_underrun", 1, 0);
        else begin
          e3 = q3[0];
          check("sel3", sel3, e3[2:0]);
          check("bit3", so3, e3[3]);
          check("last3", sl3, e3[4]);
          if (ser_ready) begin
            void'(q3.pop_front());
            pl3 = e3[4];
          end
        end
      end
    end
  end

  // drive a word to u1; returns the cycle count right after acceptance
  task automatic send1(input logic [7:0] w, output int t_acc);
    bit ok = 0;
    push_frame(w, 1, 0);
    in_data = w;
    iv1 = 1'b1;
    for (int i = 0; i < 40 && !ok; i++) begin
      @(negedge clk);
      if (ir1) ok = 1;
    end
    if (!ok) check("accept_timeout", 0, 1);
    @(posedge clk); #1;
    iv1 = 1'b0;
    t_acc = cyc;
  endtask

  task automatic wait_done(input string tag, input int t0, input int exp_len, input bit use3);
    bit ok = 0;
    for (int i = 0; i < 100 && !ok; i++) begin
      @(negedge clk);
      if ((use3 ? d3 : d1) && cyc > t0) ok = 1;
    end
    if (!ok) check({tag, "_timeout"}, 0, 1);
    else check(tag, cyc - t0, exp_len);
  endtask

  initial begin
    int ta, tb;
    bit ok;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("rst_sel", sel1, 0);
    check("rst_a", a1, 0);
    check("rst_sv", sv1, 0);
    check("rst_last", sl1, 0);
    check("rst_ir", ir1, 1);
    check("rst_ir3", ir3, 1);
    @(posedge clk); #1;

    // basic frame
    send1(8'b0000_1010, ta);
    wait_done("len_basic", ta, 8, 0);
    #1 check("ir_after", ir1, 1);

    // stall three cycles with sel at 3
    @(posedge clk); #1;
    send1(8'b0000_1010, ta);
    ok = 0;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      if (sel1 == 3'd2) ok = 1;
    end
    if (!ok) check("stall_sync", 0, 1);
    @(posedge clk); #1 ser_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1 ser_ready = 1'b1;
    wait_done("len_stall", ta, 11, 0);

    // back-to-back
    @(posedge clk); #1;
    send1(8'hA5, ta);
    send1(8'h3C, tb);
    check("b2b_gap", tb - ta, 8);
    @(negedge clk);
    check("b2b_sv", sv1, 1);
    wait_done("len_b2b", tb, 8, 0);

    // in_valid noise while running
    @(posedge clk); #1;
    send1(8'h69, ta);
    for (int i = 0; i < 5; i++) begin
      iv1 = i[0];
      in_data = 8'($urandom);
      @(negedge clk);
      check("noise_ir", ir1, 0);
      check("noise_a", a1, 8'h69);
      @(posedge clk); #1;
    end
    iv1 = 1'b0;
    wait_done("len_noise", ta, 8, 0);

    // HOLD=3 instance
    @(posedge clk); #1;
    push_frame(8'hF0, 3, 1);
    in_data = 8'hF0;
    iv3 = 1'b1;
    @(negedge clk);
    check("ir3_idle", ir3, 1);
    @(posedge clk); #1;
    iv3 = 1'b0;
    ta = cyc;
    wait_done("len_hold3", ta, 24, 1);

    // reset mid-frame at sel=5
    @(posedge clk); #1;
    send1(8'hC3, ta);
    ok = 0;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      if (sel1 == 3'd5) ok = 1;
    end
    if (!ok) check("rst_sync", 0, 1);
    #1 rst_n = 1'b0;
    q1.delete();
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    check("mrst_sel", sel1, 0);
    check("mrst_a", a1, 0);
    check("mrst_sv", sv1, 0);
    check("mrst_ir", ir1, 1);
    repeat (5) begin
      @(negedge clk);
      check("mrst_nodone", d1, 0);
    end

    check("q1_drained", q1.size(), 0);
    check("q3_drained", q3.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
    $finish;
  end

endmodule
